// File: rtl/wb_commit_stage_pkg.sv
// Shared definitions for the write-back commit stage: opcode-info bit
// positions, load funct3 encodings and the FSM state type.
package wb_commit_stage_pkg;

  localparam int OP_JAL  = 9;
  localparam int OP_JALR = 8;
  localparam int OP_LOAD = 3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

endpackage

// File: rtl/wb_commit_stage_if.sv
// Memory-stage to write-back handshake bundle.
// Handshake: an instruction transfers on a rising edge where m_valid && m_ready;
// m_* payload is only sampled on that edge, and m_ready never depends on m_valid.
interface wb_commit_stage_if #(
  parameter int WIDTH    = 64,
  parameter int OP_SIZE  = 12,
  parameter int GPR_SIZE = 5
);
  logic                m_valid;
  logic                m_ready;
  logic [OP_SIZE-1:0]  m_opcode_info;
  logic [2:0]          m_funct3;
  logic [WIDTH-1:0]    m_alu_result;
  logic [WIDTH-1:0]    m_pc;
  logic [GPR_SIZE-1:0] m_rd;
  logic                m_reg_wen;

  modport master (
    output m_valid, m_opcode_info, m_funct3, m_alu_result, m_pc, m_rd, m_reg_wen,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_opcode_info, m_funct3, m_alu_result, m_pc, m_rd, m_reg_wen,
    output m_ready
  );
endinterface

// File: rtl/wb_load_align.sv
// Combinational load aligner: shifts the raw word down to the addressed byte
// and sign/zero-extends according to funct3.
module wb_load_align
  import wb_commit_stage_pkg::*;
#(
  parameter int WIDTH = 64,
  localparam int OFF_W = $clog2(WIDTH / 8)
) (
  input  logic [WIDTH-1:0] raw,
  input  logic [OFF_W-1:0] offset,
  input  logic [2:0]       funct3,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] shifted;

  assign shifted = raw >> {offset, 3'b000};

  // At WIDTH=32 the 32-bit extensions collapse to the full word, so LWU and
  // LD naturally behave as LW without a special case.
  always_comb begin
    data = shifted;
    case (funct3)
      F3_LB:   data = WIDTH'($signed(shifted[7:0]));
      F3_LH:   data = WIDTH'($signed(shifted[15:0]));
      F3_LW:   data = WIDTH'($signed(shifted[31:0]));
      F3_LBU:  data = WIDTH'(shifted[7:0]);
      F3_LHU:  data = WIDTH'(shifted[15:0]);
      F3_LWU:  data = WIDTH'(shifted[31:0]);
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/wb_commit_stage.sv
// Registered write-back stage: commits one instruction per cycle, parks loads
// in WAIT_LOAD until data returns, and counts retired instructions.
module wb_commit_stage
  import wb_commit_stage_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int OP_SIZE   = 12,
  parameter int GPR_SIZE  = 5,
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wb_commit_stage_if.slave     m,
  input  logic                 mem_rvalid,
  input  logic [WIDTH-1:0]     mem_rdata,
  output logic                 wb_reg_wen,
  output logic [GPR_SIZE-1:0]  wb_rd,
  output logic [WIDTH-1:0]     wb_data,
  output logic [CNT_WIDTH-1:0] retire_cnt,
  output state_t               state_dbg
);

  localparam int OFF_W = $clog2(WIDTH / 8);

  state_t              state;
  logic [2:0]          ld_funct3;
  logic [OFF_W-1:0]    ld_off;
  logic [GPR_SIZE-1:0] ld_rd;
  logic                ld_wen;
  logic [WIDTH-1:0]    load_data;
  logic                is_load;
  logic                is_jump;
  logic                unused_opcode;

  assign is_load       = m.m_opcode_info[OP_LOAD];
  assign is_jump       = m.m_opcode_info[OP_JAL] | m.m_opcode_info[OP_JALR];
  assign unused_opcode = ^m.m_opcode_info;
  assign m.m_ready     = (state == IDLE);
  assign state_dbg     = state;

  wb_load_align #(.WIDTH(WIDTH)) u_align (
    .raw    (mem_rdata),
    .offset (ld_off),
    .funct3 (ld_funct3),
    .data   (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ld_funct3  <= '0;
      ld_off     <= '0;
      ld_rd      <= '0;
      ld_wen     <= 1'b0;
      wb_reg_wen <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      retire_cnt <= '0;
    end else begin
      // Write strobe is a single-cycle pulse; rd/data hold between commits.
      wb_reg_wen <= 1'b0;
      case (state)
        IDLE: begin
          if (m.m_valid) begin
            if (is_load) begin
              ld_funct3 <= m.m_funct3;
              ld_off    <= m.m_alu_result[OFF_W-1:0];
              ld_rd     <= m.m_rd;
              ld_wen    <= m.m_reg_wen;
              state     <= WAIT_LOAD;
            end else begin
              wb_reg_wen <= m.m_reg_wen && (m.m_rd != '0);
              wb_rd      <= m.m_rd;
              wb_data    <= is_jump ? (m.m_pc + WIDTH'(4)) : m.m_alu_result;
              retire_cnt <= retire_cnt + CNT_WIDTH'(1);
            end
          end
        end
        WAIT_LOAD: begin
          if (mem_rvalid) begin
            wb_reg_wen <= ld_wen && (ld_rd != '0);
            wb_rd      <= ld_rd;
            wb_data    <= load_data;
            retire_cnt <= retire_cnt + CNT_WIDTH'(1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage (64-bit datapath, 4-bit retire counter).
module tb_wb_commit_stage;
  import wb_commit_stage_pkg::*;

  localparam int W  = 64;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          mem_rvalid;
  logic [W-1:0]  mem_rdata;
  logic          wb_reg_wen;
  logic [4:0]    wb_rd;
  logic [W-1:0]  wb_data;
  logic [CW-1:0] retire_cnt;
  state_t        state_dbg;

  int n_cmp;
  int n_fail;
  logic [CW-1:0] exp_cnt;

  wb_commit_stage_if #(.WIDTH(W), .OP_SIZE(12), .GPR_SIZE(5)) m_if ();

  wb_commit_stage #(.WIDTH(W), .OP_SIZE(12), .GPR_SIZE(5), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m          (m_if.slave),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wb_reg_wen (wb_reg_wen),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .retire_cnt (retire_cnt),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [11:0] OPI_ALU  = 12'h001;
  localparam logic [11:0] OPI_LOAD = 12'h008;
  localparam logic [11:0] OPI_JALR = 12'h100;
  localparam logic [11:0] OPI_JAL  = 12'h200;

  // driver: present one instruction for one cycle, return #1 after the edge
  task automatic drive_op(input logic [11:0] op, input logic [2:0] f3,
                          input logic [W-1:0] alu, input logic [W-1:0] pc,
                          input logic [4:0] rd, input logic wen);
    m_if.m_opcode_info = op;
    m_if.m_funct3      = f3;
    m_if.m_alu_result  = alu;
    m_if.m_pc          = pc;
    m_if.m_rd          = rd;
    m_if.m_reg_wen     = wen;
    m_if.m_valid       = 1'b1;
    @(posedge clk); #1;
    m_if.m_valid       = 1'b0;
    m_if.m_alu_result  = 64'hBAD0_BAD0_BAD0_BAD0;
  endtask

  // driver: issue a load, hold off data for `waits` cycles, then return it
  task automatic run_load(input logic [2:0] f3, input logic [W-1:0] addr,
                          input logic [W-1:0] rdata, input int waits, input logic [4:0] rd,
                          output logic [W-1:0] data, output logic wen, output int low);
    drive_op(OPI_LOAD, f3, addr, 64'h0, rd, 1'b1);
    low = 0;
    for (int i = 0; i <= waits; i++) begin
      if (m_if.m_ready === 1'b0) low++;
      mem_rvalid = (i == waits);
      mem_rdata  = (i == waits) ? rdata : 64'hDEAD_BEEF_CAFE_F00D;
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
    data = wb_data;
    wen  = wb_reg_wen;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++; if (m_if.m_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", m_if.m_ready); end
    n_cmp++; if (wb_reg_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen got %b want 0", wb_reg_wen); end
    n_cmp++; if (wb_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd got %0d want 0", wb_rd); end
    n_cmp++; if (wb_data !== 64'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", wb_data); end
    n_cmp++; if (retire_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", retire_cnt); end
    n_cmp++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d want IDLE", state_dbg); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_cnt = '0;
  endtask

  task automatic test_alu();
    drive_op(OPI_ALU, 3'b000, 64'h1234, 64'h40, 5'd5, 1'b1);
    exp_cnt = exp_cnt + 4'd1;
    n_cmp++; if (wb_reg_wen !== 1'b1) begin n_fail++; $display("FAIL alu_wen got %b want 1", wb_reg_wen); end
    n_cmp++; if (wb_rd !== 5'd5) begin n_fail++; $display("FAIL alu_rd got %0d want 5", wb_rd); end
    n_cmp++; if (wb_data !== 64'h1234) begin n_fail++; $display("FAIL alu_data got %h want 1234", wb_data); end
    n_cmp++; if (retire_cnt !== exp_cnt) begin n_fail++; $display("FAIL alu_cnt got %0d want %0d", retire_cnt, exp_cnt); end
    @(posedge clk); #1;
    n_cmp++; if (wb_reg_wen !== 1'b0) begin n_fail++; $display("FAIL hold_wen got %b want 0", wb_reg_wen); end
    n_cmp++; if (wb_data !== 64'h1234 || wb_rd !== 5'd5) begin n_fail++; $display("FAIL hold_data got %h/%0d want 1234/5", wb_data, wb_rd); end
    n_cmp++; if (retire_cnt !== exp_cnt) begin n_fail++; $display("FAIL hold_cnt got %0d want %0d", retire_cnt, exp_cnt); end
  endtask

  task automatic test_jump();
    drive_op(OPI_JALR, 3'b000, 64'h7777, 64'h8000_0000, 5'd1, 1'b1);
    exp_cnt = exp_cnt + 4'd1;
    n_cmp++; if (wb_data !== 64'h8000_0004) begin n_fail++; $display("FAIL jalr_data got %h want 80000004", wb_data); end
    n_cmp++; if (wb_rd !== 5'd1 || wb_reg_wen !== 1'b1) begin n_fail++; $display("FAIL jalr_rd got %0d/%b want 1/1", wb_rd, wb_reg_wen); end
    drive_op(OPI_JAL, 3'b000, 64'h5555, 64'hFFFF_FFFF_FFFF_FFFC, 5'd2, 1'b1);
    exp_cnt = exp_cnt + 4'd1;
    n_cmp++; if (wb_data !== 64'h0) begin n_fail++; $display("FAIL jal_data got %h want 0", wb_data); end
    n_cmp++; if (retire_cnt !== exp_cnt) begin n_fail++; $display("FAIL jal_cnt got %0d want %0d", retire_cnt, exp_cnt); end
  endtask

  task automatic test_load();
    logic [2:0]   f3_v   [9];
    logic [W-1:0] addr_v [9];
    logic [W-1:0] raw_v  [9];
    logic [W-1:0] exp_v  [9];
    int           wait_v [9];
    logic [W-1:0] d;
    logic         wen;
    int           low;
    f3_v[0] = 3'b000; addr_v[0] = 64'h1003; raw_v[0] = 64'h0000_0000_8000_0000; exp_v[0] = 64'hFFFF_FFFF_FFFF_FF80; wait_v[0] = 4;
    f3_v[1] = 3'b100; addr_v[1] = 64'h1003; raw_v[1] = 64'h0000_0000_8000_0000; exp_v[1] = 64'h80;                  wait_v[1] = 4;
    f3_v[2] = 3'b001; addr_v[2] = 64'h2006; raw_v[2] = 64'h8001_0000_0000_0000; exp_v[2] = 64'hFFFF_FFFF_FFFF_8001; wait_v[2] = 1;
    f3_v[3] = 3'b101; addr_v[3] = 64'h2006; raw_v[3] = 64'h8001_0000_0000_0000; exp_v[3] = 64'h8001;                wait_v[3] = 2;
    f3_v[4] = 3'b010; addr_v[4] = 64'h3004; raw_v[4] = 64'h8765_4321_0000_0000; exp_v[4] = 64'hFFFF_FFFF_8765_4321; wait_v[4] = 0;
    f3_v[5] = 3'b110; addr_v[5] = 64'h3004; raw_v[5] = 64'h8765_4321_0000_0000; exp_v[5] = 64'h8765_4321;           wait_v[5] = 3;
    f3_v[6] = 3'b011; addr_v[6] = 64'h4000; raw_v[6] = 64'h0123_4567_89AB_CDEF; exp_v[6] = 64'h0123_4567_89AB_CDEF; wait_v[6] = 0;
    f3_v[7] = 3'b111; addr_v[7] = 64'h4000; raw_v[7] = 64'hFEDC_BA98_7654_3210; exp_v[7] = 64'hFEDC_BA98_7654_3210; wait_v[7] = 1;
    f3_v[8] = 3'b000; addr_v[8] = 64'h5001; raw_v[8] = 64'h0000_0000_0000_7F00; exp_v[8] = 64'h7F;                  wait_v[8] = 0;
    for (int k = 0; k < 9; k++) begin
      run_load(f3_v[k], addr_v[k], raw_v[k], wait_v[k], 5'(10 + k), d, wen, low);
      exp_cnt = exp_cnt + 4'd1;
      n_cmp++; if (d !== exp_v[k]) begin n_fail++; $display("FAIL load%0d_data got %h want %h", k, d, exp_v[k]); end
      n_cmp++; if (wen !== 1'b1 || wb_rd !== 5'(10 + k)) begin n_fail++; $display("FAIL load%0d_wen got %b/%0d want 1/%0d", k, wen, wb_rd, 10 + k); end
      n_cmp++; if (low !== wait_v[k] + 1) begin n_fail++; $display("FAIL load%0d_busy got %0d want %0d", k, low, wait_v[k] + 1); end
      n_cmp++; if (m_if.m_ready !== 1'b1) begin n_fail++; $display("FAIL load%0d_ready got %b want 1", k, m_if.m_ready); end
      n_cmp++; if (retire_cnt !== exp_cnt) begin n_fail++; $display("FAIL load%0d_cnt got %0d want %0d", k, retire_cnt, exp_cnt); end
    end
  endtask

  task automatic test_rd_zero();
    drive_op(OPI_ALU, 3'b000, 64'h99, 64'h0, 5'd0, 1'b1);
    exp_cnt = exp_cnt + 4'd1;
    n_cmp++; if (wb_reg_wen !== 1'b0) begin n_fail++; $display("FAIL rd0_wen got %b want 0", wb_reg_wen); end
    n_cmp++; if (retire_cnt !== exp_cnt) begin n_fail++; $display("FAIL rd0_cnt got %0d want %0d", retire_cnt, exp_cnt); end
    drive_op(OPI_ALU, 3'b000, 64'hAB, 64'h0, 5'd7, 1'b0);
    exp_cnt = exp_cnt + 4'd1;
    n_cmp++; if (wb_reg_wen !== 1'b0 || wb_data !== 64'hAB) begin n_fail++; $display("FAIL nowen got %b/%h want 0/ab", wb_reg_wen, wb_data); end
    n_cmp++; if (retire_cnt !== exp_cnt) begin n_fail++; $display("FAIL nowen_cnt got %0d want %0d", retire_cnt, exp_cnt); end
  endtask

  task automatic test_rvalid_idle();
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h1111;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    n_cmp++; if (wb_reg_wen !== 1'b0 || retire_cnt !== exp_cnt) begin n_fail++; $display("FAIL idle_rvalid got %b/%0d want 0/%0d", wb_reg_wen, retire_cnt, exp_cnt); end
    n_cmp++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL idle_rvalid_state got %0d want IDLE", state_dbg); end
  endtask

  task automatic test_reset_mid_load();
    drive_op(OPI_LOAD, 3'b011, 64'h8000, 64'h0, 5'd9, 1'b1);
    n_cmp++; if (state_dbg !== WAIT_LOAD) begin n_fail++; $display("FAIL midrst_state got %0d want WAIT_LOAD", state_dbg); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #3;
    n_cmp++; if (m_if.m_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b want 1", m_if.m_ready); end
    rst_n = 1'b1;
    exp_cnt = '0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h4444_4444;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    n_cmp++; if (wb_reg_wen !== 1'b0 || wb_data !== 64'h0) begin n_fail++; $display("FAIL midrst_write got %b/%h want 0/0", wb_reg_wen, wb_data); end
    n_cmp++; if (retire_cnt !== 4'd0) begin n_fail++; $display("FAIL midrst_cnt got %0d want 0", retire_cnt); end
    n_cmp++; if (m_if.m_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready_after got %b want 1", m_if.m_ready); end
  endtask

  task automatic test_back_to_back_wrap();
    m_if.m_opcode_info = OPI_ALU;
    m_if.m_reg_wen     = 1'b1;
    m_if.m_pc          = 64'h0;
    m_if.m_funct3      = 3'b000;
    for (int i = 0; i < 16; i++) begin
      m_if.m_alu_result = 64'(i + 100);
      m_if.m_rd         = 5'(i + 1);
      m_if.m_valid      = 1'b1;
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 4'd1;
      n_cmp++; if (wb_reg_wen !== 1'b1 || wb_data !== 64'(i + 100)) begin n_fail++; $display("FAIL b2b%0d got %b/%h want 1/%h", i, wb_reg_wen, wb_data, 64'(i + 100)); end
      n_cmp++; if (retire_cnt !== exp_cnt) begin n_fail++; $display("FAIL b2b%0d_cnt got %0d want %0d", i, retire_cnt, exp_cnt); end
    end
    m_if.m_valid = 1'b0;
    n_cmp++; if (retire_cnt !== 4'd0) begin n_fail++; $display("FAIL wrap_cnt got %0d want 0", retire_cnt); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    exp_cnt = '0;
    rst_n = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    m_if.m_valid = 1'b0;
    m_if.m_opcode_info = '0;
    m_if.m_funct3 = '0;
    m_if.m_alu_result = '0;
    m_if.m_pc = '0;
    m_if.m_rd = '0;
    m_if.m_reg_wen = 1'b0;
    test_reset();
    test_alu();
    test_jump();
    test_load();
    test_rd_zero();
    test_rvalid_idle();
    test_reset_mid_load();
    test_back_to_back_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_commit_stage.md
# wb_commit_stage

Registered, handshaked write-back stage for the rv64 pipeline, the successor to the purely combinational write-back mux. It accepts one retiring instruction per cycle from the memory stage, waits for variable-latency load data, aligns and sign/zero-extends it, and drives a single registered GPR write port plus a retired-instruction counter. It sits between the memory stage and the register file and forwarding network.

## Interface
- `WIDTH`, 64: datapath width; 32 or 64 only.
- `OP_SIZE`, 12: one-hot opcode-info vector width.
- `GPR_SIZE`, 5: register index width.
- `CNT_WIDTH`, 64: retire-counter width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `m_valid`  in  1  memory stage presents an instruction.
- `m_ready`  out  1  stage can accept; equals (state == IDLE).
- `m_opcode_info`  in  OP_SIZE  one-hot decode; bit 9 = jal, bit 8 = jalr, bit 3 = load.
- `m_funct3`  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
- `m_alu_result`  in  WIDTH  ALU result, or load effective address.
- `m_pc`  in  WIDTH  instruction PC.
- `m_rd`  in  GPR_SIZE  destination register.
- `m_reg_wen`  in  1  instruction writes rd.
- `mem_rvalid`  in  1  load data valid this cycle.
- `mem_rdata`  in  WIDTH  aligned-to-word raw memory data.
- `wb_reg_wen`  out  1  registered one-cycle write strobe.
- `wb_rd`  out  GPR_SIZE  registered destination.
- `wb_data`  out  WIDTH  registered write data.
- `retire_cnt`  out  CNT_WIDTH  instructions committed since reset.

## Operation
- FSM states: IDLE, WAIT_LOAD.
- IDLE, `m_valid`=1, load bit clear: commit on this edge. Data = `m_pc + 4` if jal or jalr, else `m_alu_result`.
- IDLE, `m_valid`=1, load bit set: latch funct3, address low bits, rd, and reg_wen; go to WAIT_LOAD. Nothing is committed.
- WAIT_LOAD, `mem_rvalid`=1: commit the aligned/extended load data and return to IDLE.
- WAIT_LOAD, `mem_rvalid`=0: hold state. `m_ready`=0.
- `mem_rvalid` in IDLE is ignored.
- Load align: byte offset = `addr[log2(WIDTH/8)-1:0]`. Shift `mem_rdata` right by offset*8, then sign- or zero-extend from 8/16/32 bits. LD returns the full word.
- WIDTH=32: LD and LWU behave as LW. Offset uses 2 bits.
- Commit: `wb_reg_wen` = latched reg_wen AND (rd != 0). `wb_rd` and `wb_data` update. `retire_cnt` increments by 1 whether or not a register is written. It wraps modulo 2^CNT_WIDTH.
- Cycles without a commit: `wb_reg_wen`=0. `wb_rd` and `wb_data` hold their last values.
- Unknown funct3 (111): treated as LD.

## Timing
- Reset values: state IDLE, `m_ready`=1, `wb_reg_wen`=0, `wb_rd`=0, `wb_data`=0, `retire_cnt`=0.
- Non-load latency: accepted at edge N, write visible in cycle N+1.
- Load: `mem_rvalid` high in cycle K, write visible in K+1. `m_ready` returns high in K+1.
- Minimum load occupancy: 2 cycles, with `mem_rvalid` in the cycle after acceptance.
- Back-to-back non-loads commit every cycle at full throughput.
- Reset asserted in WAIT_LOAD: the pending load is dropped and nothing is written. After deassertion the stage is IDLE; a stale `mem_rvalid` is ignored.
- `m_*` inputs are sampled only when `m_valid && m_ready`.

## Structure
- Shared package holds:
  - opcode-info bit indices: JAL=9, JALR=8, LOAD=3.
  - funct3 load encodings.
  - state enum {IDLE, WAIT_LOAD}.
- Sub-module `wb_load_align` (combinational): inputs raw data, offset, funct3; output extended WIDTH-bit value. Parametrised by WIDTH.
- Top module holds the FSM, load-context registers, output registers and counter.

## Test plan
- Reset, then ADD rd=5 with alu=0x1234 -> next cycle `wb_reg_wen`=1, `wb_rd`=5, `wb_data`=0x1234, `retire_cnt`=1.
- jalr with pc=0x8000_0000, rd=1 -> `wb_data`=0x8000_0004.
- LB with addr offset 3, `mem_rdata`=0x0000_0000_8000_0000 after 4 wait cycles -> `m_ready`=0 for 5 cycles; `wb_data`=0xFFFF_FFFF_FFFF_FF80. Same case as LBU -> 0x80.
- Non-load with rd=0 and reg_wen=1 -> `wb_reg_wen`=0, `retire_cnt` increments.
- Load accepted, `rst_n` pulsed low mid-wait, then `mem_rvalid`=1 -> no write, `retire_cnt`=0, `m_ready`=1.
- Start with `retire_cnt` at all-ones (CNT_WIDTH=4, 15 commits) -> 16th commit wraps to 0. Back-to-back non-loads produce a commit every cycle.
